// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requester channels, the arbiter and the UART transmitter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface uart_tx_arbiter_if #(
    parameter int C_N_REQ           = 4,
    parameter int C_UART_DATA_WIDTH = 8
);
    localparam int GW = (C_N_REQ > 1) ? $clog2(C_N_REQ) : 1;

    logic [C_N_REQ-1:0]                   req_valid;
    logic [C_N_REQ*C_UART_DATA_WIDTH-1:0] req_data;
    logic [C_N_REQ-1:0]                   req_ready;
    logic [C_UART_DATA_WIDTH-1:0]         tx_data;
    logic                                 tx_send;
    logic                                 tx_busy;
    logic                                 tx_error;
    logic                                 err_clr;
    logic                                 err;
    logic [GW-1:0]                        grant_id;
    logic                                 active;

    modport slave (
        input  req_valid, req_data, tx_busy, tx_error, err_clr,
        output req_ready, tx_data, tx_send, err, grant_id, active
    );

    modport master (
        output req_valid, req_data, tx_busy, tx_error, err_clr,
        input  req_ready, tx_data, tx_send, err, grant_id, active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one requester word at a time to a UART transmitter,
// with a send-acknowledge timeout and a sticky error flag.
module uart_tx_arbiter #(
    parameter int C_N_REQ           = 4,
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_TIMEOUT         = 16
) (
    input  logic              clk,
    input  logic              rstb,
    uart_tx_arbiter_if.slave  bus
);
    localparam int GW = (C_N_REQ > 1) ? $clog2(C_N_REQ) : 1;
    localparam int CW = $clog2(C_TIMEOUT) + 1;
    localparam int W  = C_UART_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

    state_t         state, state_next;
    logic [GW-1:0]  ptr, ptr_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           tx_send_r, tx_send_next;
    logic [W-1:0]   tx_data_r, tx_data_next;
    logic [C_N_REQ-1:0] ready_r, ready_next;
    logic [GW-1:0]  grant_r, grant_next;
    logic           err_r, err_next;
    logic           active_r, active_next;
    logic           timeout;

    logic [GW-1:0]  sel;
    logic [GW-1:0]  rr_pos;
    logic           found;
    int             rr_idx;
    logic [W-1:0]   words [C_N_REQ];

    for (genvar g = 0; g < C_N_REQ; g++) begin : g_unpack
        assign words[g] = bus.req_data[g*W +: W];
    end

    // First valid channel found walking upward from ptr, wrapping past the top channel.
    always_comb begin
        sel    = '0;
        found  = 1'b0;
        rr_idx = 0;
        rr_pos = '0;
        for (int k = 0; k < C_N_REQ; k++) begin
            rr_idx = int'(ptr) + k;
            if (rr_idx >= C_N_REQ) begin
                rr_idx = rr_idx - C_N_REQ;
            end
            rr_pos = GW'(rr_idx);
            if (!found && bus.req_valid[rr_pos]) begin
                found = 1'b1;
                sel   = rr_pos;
            end
        end
    end

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        cnt_next     = cnt;
        tx_send_next = tx_send_r;
        tx_data_next = tx_data_r;
        ready_next   = '0;
        grant_next   = grant_r;
        timeout      = 1'b0;

        case (state)
            IDLE: begin
                if (!bus.tx_busy && found) begin
                    state_next      = SEND;
                    cnt_next        = '0;
                    tx_send_next    = 1'b1;
                    tx_data_next    = words[sel];
                    ready_next[sel] = 1'b1;
                    grant_next      = sel;
                    ptr_next        = (sel == GW'(C_N_REQ - 1)) ? '0 : sel + 1'b1;
                end
            end
            SEND: begin
                if (bus.tx_busy) begin
                    state_next   = DRAIN;
                    tx_send_next = 1'b0;
                end else if (cnt == CW'(C_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: abandon this word and flag it.
                    timeout      = 1'b1;
                    tx_send_next = 1'b0;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (!bus.tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                tx_send_next = 1'b0;
            end
        endcase

        active_next = (state_next != IDLE);

        // Setting beats clearing when both happen in the same cycle.
        err_next = err_r;
        if (bus.err_clr) begin
            err_next = 1'b0;
        end
        if (timeout || (bus.tx_error && active_r)) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            tx_send_r <= 1'b0;
            tx_data_r <= '0;
            ready_r   <= '0;
            grant_r   <= '0;
            err_r     <= 1'b0;
            active_r  <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            cnt       <= cnt_next;
            tx_send_r <= tx_send_next;
            tx_data_r <= tx_data_next;
            ready_r   <= ready_next;
            grant_r   <= grant_next;
            err_r     <= err_next;
            active_r  <= active_next;
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.tx_send   = tx_send_r;
    assign bus.grant_id  = grant_r;
    assign bus.err       = err_r;
    assign bus.active    = active_r;
endmodule
